// File: rtl/ser_xmt_fifo_if.sv
// Byte-write / status bundle between the serial register block and the transmitter.
// Latency: n/a (wires only).
// Backpressure: rdy low tells the writer that further bytes will be dropped.
interface ser_xmt_fifo_if #(
    parameter int DEPTH_LOG2 = 4
);
    logic                  wr;
    logic [7:0]            data_in;
    logic                  rdy;
    logic                  empty;
    logic [DEPTH_LOG2:0]   count;
    logic                  txd;

    // Register block side: writes bytes, reads status and observes the line.
    modport master (
        output wr,
        output data_in,
        input  rdy,
        input  empty,
        input  count,
        input  txd
    );

    // Transmitter side.
    modport slave (
        input  wr,
        input  data_in,
        output rdy,
        output empty,
        output count,
        output txd
    );
endinterface

// File: rtl/ser_xmt_fifo.sv
// Buffered 8N1 serial transmitter: byte FIFO feeding a start/data/stop serializer.
// Latency: byte written at edge N into an idle empty block drives txd low after edge N+1.
// Backpressure: rdy=0 when the FIFO is full; writes while rdy=0 are silently dropped.
module ser_xmt_fifo #(
    parameter int CLK_FREQ   = 50000000,
    parameter int BAUD       = 115200,
    parameter int DEPTH_LOG2 = 4
) (
    input  logic          clk,
    input  logic          rst,
    ser_xmt_fifo_if.slave bus
);
    localparam int DIV   = CLK_FREQ / BAUD;
    localparam int BW    = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam logic [BW-1:0]         BAUD_LAST = BW'(DIV - 1);
    localparam logic [DEPTH_LOG2:0]   FULL      = (DEPTH_LOG2 + 1)'(DEPTH);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t                 state, state_nxt;
    logic [BW-1:0]          baud_cnt, baud_nxt;
    logic [2:0]             bit_idx, bit_nxt;
    logic [7:0]             shift, shift_nxt;
    logic                   txd, txd_nxt;
    logic [DEPTH_LOG2-1:0]  wr_ptr, rd_ptr;
    logic [DEPTH_LOG2:0]    count, count_nxt;
    logic                   rdy, empty;
    logic [7:0]             mem [DEPTH];
    logic                   push, pop, bit_end, have_byte;

    // rdy is already registered as "not full", so a full FIFO refuses the
    // write even on an edge where the serializer pops.
    assign push      = bus.wr & rdy;
    assign bit_end   = (baud_cnt == BAUD_LAST);
    assign have_byte = (count != '0);

    assign bus.rdy   = rdy;
    assign bus.empty = empty;
    assign bus.count = count;
    assign bus.txd   = txd;

    // Serializer next state, next line level and pop request.
    always_comb begin
        state_nxt = state;
        baud_nxt  = bit_end ? '0 : baud_cnt + 1'b1;
        bit_nxt   = bit_idx;
        shift_nxt = shift;
        txd_nxt   = txd;
        pop       = 1'b0;
        case (state)
            IDLE: begin
                baud_nxt = '0;
                txd_nxt  = 1'b1;
                if (have_byte) begin
                    pop       = 1'b1;
                    shift_nxt = mem[rd_ptr];
                    state_nxt = START;
                    txd_nxt   = 1'b0;
                end
            end
            START: begin
                if (bit_end) begin
                    state_nxt = DATA;
                    bit_nxt   = 3'd0;
                    txd_nxt   = shift[0];
                end
            end
            DATA: begin
                if (bit_end) begin
                    if (bit_idx == 3'd7) begin
                        state_nxt = STOP;
                        txd_nxt   = 1'b1;
                    end else begin
                        bit_nxt = bit_idx + 3'd1;
                        txd_nxt = shift[bit_idx + 3'd1];
                    end
                end
            end
            STOP: begin
                if (bit_end) begin
                    // Back-to-back frames: the next start bit follows the
                    // stop bit with no idle cycle in between.
                    if (have_byte) begin
                        pop       = 1'b1;
                        shift_nxt = mem[rd_ptr];
                        state_nxt = START;
                        txd_nxt   = 1'b0;
                    end else begin
                        state_nxt = IDLE;
                        txd_nxt   = 1'b1;
                    end
                end
            end
            default: begin
                state_nxt = IDLE;
                txd_nxt   = 1'b1;
            end
        endcase
    end

    // FIFO occupancy; a push and a pop on the same edge cancel.
    always_comb begin
        count_nxt = count;
        if (push && !pop) begin
            count_nxt = count + 1'b1;
        end else if (pop && !push) begin
            count_nxt = count - 1'b1;
        end
    end

    // Control state, pointers and registered status outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= IDLE;
            baud_cnt <= '0;
            bit_idx  <= '0;
            shift    <= '0;
            txd      <= 1'b1;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            rdy      <= 1'b1;
            empty    <= 1'b1;
        end else begin
            state    <= state_nxt;
            baud_cnt <= baud_nxt;
            bit_idx  <= bit_nxt;
            shift    <= shift_nxt;
            txd      <= txd_nxt;
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            count    <= count_nxt;
            rdy      <= (count_nxt != FULL);
            empty    <= (count_nxt == '0) && (state_nxt == IDLE);
        end
    end

    // Byte storage; contents are only meaningful between the pointers.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= bus.data_in;
        end
    end
endmodule
